// File: rtl/ahb_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb_mem_slave
//   AHB-Lite responder backed by a word-organised, byte-addressable memory.
//   The low REGISTER_SELECT_BITS of the address form a byte offset into
//   MEMORY_DEPTH 32-bit words. The slave handles byte, halfword and word
//   transfers. It returns the two-cycle ERROR response for an out-of-range
//   offset, an hsize above 2, or a misaligned halfword or word.
//
//   Optional feature (compile-time macro AHB_SLAVE_WAIT_EN):
//     defined   - every OKAY data phase inserts WAIT_STATES wait cycles
//     undefined - every OKAY data phase is zero-wait and has no counter
//
// Ports:
//   i_hclk       clock, rising edge
//   i_hreset     asynchronous active-low reset
//   i_hsel       slave select from the decoder
//   i_haddr      transfer address
//   i_hwrite     1 = write, 0 = read
//   i_hsize      0 = byte, 1 = halfword, 2 = word
//   i_htrans     IDLE / BUSY / NONSEQ / SEQ
//   i_hwdata     write data (data phase)
//   i_hready     muxed bus hready
//   o_hrdata     read data (zero outside read data phases)
//   o_hresp      0 = OKAY, 1 = ERROR
//   o_hreadyout  slave ready
// ---------------------------------------------------------------------------
module ahb_mem_slave #(
    parameter int ADDR_WIDTH           = 32,
    parameter int DATA_WIDTH           = 32,
    parameter int REGISTER_SELECT_BITS = 12,
    parameter int MEMORY_DEPTH         = 256,
    parameter int WAIT_STATES          = 2
) (
    input  logic                  i_hclk,
    input  logic                  i_hreset,
    input  logic                  i_hsel,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic                  i_hwrite,
    input  logic [2:0]            i_hsize,
    input  logic [1:0]            i_htrans,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    input  logic                  i_hready,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_hresp,
    output logic                  o_hreadyout
);

    localparam int WORD_AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam int OFS_W   = WORD_AW + 2;
    localparam int MEM_BYTES_I = 4 * MEMORY_DEPTH;
    localparam logic [REGISTER_SELECT_BITS:0] MEM_BYTES = MEM_BYTES_I[REGISTER_SELECT_BITS:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                          state;
    logic [OFS_W-1:0]                addr_q;
    logic                            hwrite_q;
    logic [1:0]                      hsize_q;
    logic [DATA_WIDTH-1:0]           mem [MEMORY_DEPTH];

    logic [REGISTER_SELECT_BITS-1:0] ofs;
    logic                            accept;
    logic                            illegal;
    logic                            wr_en;
    logic [3:0]                      be;
    logic [WORD_AW-1:0]              widx;

`ifdef AHB_SLAVE_WAIT_EN
    localparam int WAIT_CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    logic [WAIT_CNT_W-1:0] wait_cnt;
`endif

    assign ofs  = i_haddr[REGISTER_SELECT_BITS-1:0];
    assign widx = addr_q[OFS_W-1:2];

    // o_hreadyout is folded in so that a transfer is never accepted while
    // this slave is itself stalling the bus.
    assign accept = i_hsel & i_hready & i_htrans[1] & o_hreadyout;

    always_comb begin
        illegal = 1'b0;
        if ({1'b0, ofs} >= MEM_BYTES)              illegal = 1'b1;
        if (i_hsize > 3'd2)                        illegal = 1'b1;
        if ((i_hsize == 3'd1) && ofs[0])           illegal = 1'b1;
        if ((i_hsize == 3'd2) && (ofs[1:0] != 2'b00)) illegal = 1'b1;
    end

    // Little-endian byte lanes for the latched size/offset.
    always_comb begin
        be = 4'b0000;
        case (hsize_q)
            2'd0:    be[addr_q[1:0]] = 1'b1;
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // The write lands on the edge that closes the data phase. Reset forces
    // the state to IDLE asynchronously, so a write that is in flight is lost.
    assign wr_en = (state == S_DATA) & hwrite_q & o_hreadyout;

    // The array has no reset.
    always_ff @(posedge i_hclk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= i_hwdata[8*b +: 8];
            end
        end
    end

    // The read is combinational from the array, so a write committed on
    // the previous edge is already visible.
    assign o_hrdata = ((state == S_DATA) && !hwrite_q) ? mem[widx] : '0;

    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            state       <= S_IDLE;
            o_hreadyout <= 1'b1;
            o_hresp     <= 1'b0;
            addr_q      <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 2'd0;
`ifdef AHB_SLAVE_WAIT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_ERR1: begin
                    // The second ERROR cycle always follows, even if the
                    // master has already cancelled with IDLE.
                    state       <= S_ERR2;
                    o_hreadyout <= 1'b1;
                    o_hresp     <= 1'b1;
                end
                default: begin
                    // IDLE, the last cycle of DATA, and ERR2 can all take a
                    // new address phase.
                    if (o_hreadyout) begin
                        if (accept) begin
                            addr_q   <= ofs[OFS_W-1:0];
                            hwrite_q <= i_hwrite;
                            hsize_q  <= i_hsize[1:0];
                            if (illegal) begin
                                state       <= S_ERR1;
                                o_hreadyout <= 1'b0;
                                o_hresp     <= 1'b1;
                            end else begin
                                state   <= S_DATA;
                                o_hresp <= 1'b0;
`ifdef AHB_SLAVE_WAIT_EN
                                wait_cnt    <= WAIT_CNT_W'(WAIT_STATES);
                                o_hreadyout <= (WAIT_STATES == 0);
`else
                                o_hreadyout <= 1'b1;
`endif
                            end
                        end else begin
                            state       <= S_IDLE;
                            o_hreadyout <= 1'b1;
                            o_hresp     <= 1'b0;
                        end
                    end
`ifdef AHB_SLAVE_WAIT_EN
                    else begin
                        // DATA wait cycle: ready rises once the count runs out.
                        wait_cnt    <= wait_cnt - WAIT_CNT_W'(1);
                        o_hreadyout <= (wait_cnt == WAIT_CNT_W'(1));
                    end
`endif
                end
            endcase
        end
    end

    // Address bits above the register-select field and htrans[0] are not
    // needed. The decoder and the accept term already cover them.
    logic unused_bits;
    generate
        if (ADDR_WIDTH > REGISTER_SELECT_BITS) begin : g_unused_hi
            assign unused_bits = ^{i_haddr[ADDR_WIDTH-1:REGISTER_SELECT_BITS], i_htrans[0]};
        end else begin : g_unused_lo
            assign unused_bits = i_htrans[0];
        end
    endgenerate

endmodule

// File: tb/tb_ahb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_mem_slave
//   The driver plays a single AHB-Lite master and pushes an expected data
//   phase response for each transfer into a scoreboard queue. A separate bus
//   monitor runs on the falling edge. It tracks pending data phases, checks
//   wait and ERROR cycles against the entry at the front of the queue, pops
//   and compares when a phase completes, and checks the idle and reset values
//   on every other cycle.
// ---------------------------------------------------------------------------
module tb_ahb_mem_slave;

    logic        i_hclk   = 1'b0;
    logic        i_hreset = 1'b1;
    logic        i_hsel   = 1'b0;
    logic [31:0] i_haddr  = '0;
    logic        i_hwrite = 1'b0;
    logic [2:0]  i_hsize  = 3'd0;
    logic [1:0]  i_htrans = 2'b00;
    logic [31:0] i_hwdata = '0;
    wire         i_hready;
    logic [31:0] o_hrdata;
    logic        o_hresp;
    logic        o_hreadyout;

    assign i_hready = o_hreadyout;

    always #5 i_hclk = ~i_hclk;

    ahb_mem_slave dut (
        .i_hclk      (i_hclk),
        .i_hreset    (i_hreset),
        .i_hsel      (i_hsel),
        .i_haddr     (i_haddr),
        .i_hwrite    (i_hwrite),
        .i_hsize     (i_hsize),
        .i_htrans    (i_htrans),
        .i_hwdata    (i_hwdata),
        .i_hready    (i_hready),
        .o_hrdata    (o_hrdata),
        .o_hresp     (o_hresp),
        .o_hreadyout (o_hreadyout)
    );

`ifdef AHB_SLAVE_WAIT_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        int          waits;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    bit   dp = 0;
    int   lo = 0;
    exp_t cur;

    always @(negedge i_hclk) begin
        if (!i_hreset) begin
            dp = 0;
            lo = 0;
            check32("reset_hreadyout", 32'(o_hreadyout), 32'd1);
            check32("reset_hresp",     32'(o_hresp),     32'd0);
            check32("reset_hrdata",    o_hrdata,         32'd0);
        end else if (dp && !o_hreadyout) begin
            lo++;
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL orphan_wait: got a stalled phase, expected no pending transfer");
            end else begin
                check32({sb[0].name, "_lowresp"}, 32'(o_hresp), 32'(sb[0].resp));
            end
        end else begin
            if (dp) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL orphan_resp: got a completed phase, expected no pending transfer");
                end else begin
                    cur = sb.pop_front();
                    check32({cur.name, "_resp"},  32'(o_hresp), 32'(cur.resp));
                    check32({cur.name, "_rdata"}, o_hrdata,     cur.rdata);
                    check32({cur.name, "_waits"}, 32'(lo),      32'(cur.waits));
                end
            end else begin
                check32("idle_hreadyout", 32'(o_hreadyout), 32'd1);
                check32("idle_hresp",     32'(o_hresp),     32'd0);
                check32("idle_hrdata",    o_hrdata,         32'd0);
            end
            lo = 0;
            dp = i_hsel & i_htrans[1] & o_hreadyout;
        end
    end

    // ---------------- driver ----------------
    // Returns 1 ns after the next rising edge that has hready high.
    task automatic wait_ready();
        int n = 0;
        forever begin
            @(negedge i_hclk);
            if (o_hreadyout) break;
            n++;
            if (n > 50) begin
                n_vec++; n_err++;
                $display("FAIL ready_timeout: got hreadyout=0 for %0d cycles, expected 1", n);
                break;
            end
        end
        @(posedge i_hclk);
        #1;
    endtask

    task automatic xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                        input logic [31:0] wd, input bit chk, input logic resp,
                        input logic [31:0] rd, input string nm);
        exp_t e;
        i_hsel   = 1'b1;
        i_haddr  = a;
        i_hwrite = wr;
        i_hsize  = sz;
        i_htrans = 2'b10;
        if (chk) begin
            e.resp  = resp;
            e.rdata = rd;
            e.waits = resp ? 1 : EXP_WAIT;
            e.name  = nm;
            sb.push_back(e);
        end
        wait_ready();
        i_hwdata = wr ? wd : 32'h0;
    endtask

    task automatic bus_idle(input int n);
        i_hsel   = 1'b0;
        i_htrans = 2'b00;
        i_hwrite = 1'b0;
        repeat (n) wait_ready();
    endtask

    localparam logic W = 1'b1, R = 1'b0;

    initial begin
        #1 i_hreset = 1'b0;
        repeat (3) @(posedge i_hclk);
        #1 i_hreset = 1'b1;

        // Word write, then a back-to-back read of the same word.
        xfer(32'h004, W, 3'd2, 32'hA5A5A5A5, 1, 0, 32'h0,        "t2_wr");
        xfer(32'h004, R, 3'd2, 32'h0,        1, 0, 32'hA5A5A5A5, "t2_rd");
        bus_idle(2);

        // Byte and halfword lane merge into a cleared word.
        xfer(32'h008, W, 3'd2, 32'h00000000, 1, 0, 32'h0,        "t3_clr");
        xfer(32'h009, W, 3'd0, 32'h11227733, 1, 0, 32'h0,        "t3_byte");
        xfer(32'h00A, W, 3'd1, 32'hBEEF5566, 1, 0, 32'h0,        "t3_half");
        xfer(32'h008, R, 3'd2, 32'h0,        1, 0, 32'hBEEF7700, "t3_rd");
        bus_idle(2);

        // Illegal transfers: two-cycle ERROR and no memory side effects.
        xfer(32'h000, W, 3'd2, 32'hCAFEF00D, 1, 0, 32'h0,        "t4_init");
        xfer(32'h400, R, 3'd2, 32'h0,        1, 1, 32'h0,        "t4_oob");
        bus_idle(1);                             // the master cancels in ERR1
        xfer(32'h003, W, 3'd1, 32'hFFFFFFFF, 1, 1, 32'h0,        "t4_mishalf");
        xfer(32'h002, W, 3'd2, 32'hFFFFFFFF, 1, 1, 32'h0,        "t4_misword");
        xfer(32'h000, W, 3'd3, 32'hFFFFFFFF, 1, 1, 32'h0,        "t4_badsize");
        xfer(32'h000, R, 3'd2, 32'h0,        1, 0, 32'hCAFEF00D, "t4_rd");
        bus_idle(2);

        // Wait-state path (zero-wait unless the macro is defined).
        xfer(32'h020, W, 3'd2, 32'h12345678, 1, 0, 32'h0,        "t5_wr");
        xfer(32'h020, R, 3'd2, 32'h0,        1, 0, 32'h12345678, "t5_rd");
        bus_idle(2);

        // IDLE and BUSY while selected, then NONSEQ while unselected.
        i_hsel = 1'b1; i_haddr = 32'h004; i_hwrite = 1'b1; i_hsize = 3'd2;
        i_hwdata = 32'hFFFFFFFF;
        i_htrans = 2'b00; repeat (2) wait_ready();
        i_htrans = 2'b01; repeat (2) wait_ready();
        i_hsel = 1'b0; i_htrans = 2'b10; repeat (2) wait_ready();
        xfer(32'h004, R, 3'd2, 32'h0,        1, 0, 32'hA5A5A5A5, "t6_rd");
        bus_idle(2);

        // Reset in the middle of a write data phase drops the write.
        xfer(32'h010, W, 3'd2, 32'h11111111, 1, 0, 32'h0,        "t1_wr");
        xfer(32'h010, W, 3'd2, 32'hDEADBEEF, 0, 0, 32'h0,        "t1_abort");
        i_hsel = 1'b0; i_htrans = 2'b00; i_hwrite = 1'b0;
        #2 i_hreset = 1'b0;
        repeat (2) @(posedge i_hclk);
        #1 i_hreset = 1'b1;
        xfer(32'h010, R, 3'd2, 32'h0,        1, 0, 32'h11111111, "t1_rd");
        bus_idle(3);

        check32("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
